or_dut_host: RTL and testbench
==============================

Name: or_dut_host

Overview:
- Bus-master driver for the register-mapped OR block (FIFO a/b → y = a|b).
- Accepts operand pairs on a valid/ready stream and issues register writes to the OR block:
  - operand A to address 4
  - operand B to address 5
- Polls the block's status registers, reads the result from address 3 and presents it on an output valid/ready stream.
- Sits between the test/host logic and the OR block; its bus ports connect 1:1 to that block's bus ports.

Parameters:
- TMO_W, 10, width of poll timeout counter
- POLL_TIMEOUT, 1000, max cycles spent in any single poll state before abort (must fit in TMO_W; covers the 256-cycle counter gate)

Ports:
- CLK  in  1  clock, all logic on posedge
- RST_N  in  1  asynchronous reset, active low
- in_valid  in  1  operand pair valid
- in_ready  out  1  host ready for an operand pair
- in_a  in  8  operand A
- in_b  in  8  operand B
- write_address  out  3  bus write address
- write_data  out  8  bus write data
- write_en  out  1  bus write strobe
- write_rdy  in  1  slave accepts write this cycle
- read_address  out  3  bus read address
- read_en  out  1  bus read strobe
- read_data  in  8  slave read data, combinational same cycle
- read_rdy  in  1  slave read data valid this cycle
- out_valid  out  1  result valid
- out_data  out  8  result (A|B as returned by the slave)
- out_ready  in  1  consumer accepts result
- busy  out  1  FSM not in IDLE
- timeout_err  out  1  sticky; set on any poll timeout
- txn_count  out  16  completed results delivered, wraps at 0xFFFF→0

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE
  - all outputs 0 except in_ready=1
  - operand regs, timeout counter, txn_count and timeout_err cleared
- Reset asserted mid-transaction: abandon immediately, no further bus strobes. Items already written to the slave are not recovered; the slave is reset from the same RST_N.
- A bus beat completes in the cycle its strobe is high and the matching rdy is high.
  - While rdy is low, hold address, data and strobe stable.
- Strobes:
  - read_en is asserted for every read beat.
  - Only the read of address 3 has a side effect (dequeue in the slave).
- FSM states, one bus beat per cycle max:
  - IDLE: in_ready=1. On in_valid: capture in_a/in_b → POLL_A.
  - POLL_A: read address 0.
    - Beat complete with read_data[0]=1 → WR_A.
    - Otherwise stay and increment the timeout counter.
  - WR_A: write address 4, data=A. On write_rdy → POLL_B.
  - POLL_B: read address 1. read_data[0]=1 → WR_B; else stay and increment.
  - WR_B: write address 5, data=B. On write_rdy → POLL_Y.
  - POLL_Y: read address 2. read_data[0]=1 → RD_Y; else stay and increment.
  - RD_Y: read address 3. On read_rdy: capture read_data into out_data → OUT.
  - OUT: out_valid=1, out_data stable.
    - On out_ready: txn_count++ and → IDLE.
    - in_ready stays 0 until IDLE.
- Status handling: only bit 0 of status reads is examined; bits 7:1 ignored.
- Timeout counter:
  - Cleared on entry to each POLL state.
  - When it reaches POLL_TIMEOUT: set timeout_err, → IDLE, no output produced, txn_count unchanged.
  - timeout_err is cleared only by reset.
- Minimum latency, zero wait states and all status=1 on first poll:
  - in handshake at cycle 0
  - bus beats at cycles 1–6
  - out_valid from cycle 7
- Simultaneous events: in_valid is ignored outside IDLE. The OUT→IDLE cycle does not accept input; the earliest accept is the following cycle.
- Bus idle values:
  - write_en=0, read_en=0, addresses=0, write_data=0 when not in the corresponding state.
  - Outputs are registered from state (Moore).

Decomposition:
- Shared package or_dut_pkg:
  - address constants A_FULL_N=0, B_FULL_N=1, Y_EMPTY_N=2, Y_DATA=3, A_DATA=4, B_DATA=5
  - data width 8, address width 3
  - state enum
- Optional sub-module or_dut_poll_timer: clear/inc/expired, TMO_W-wide, parameter POLL_TIMEOUT.
- All else inline.

Test Plan:
- Reset, then in_a=0x0F, in_b=0xF0 with out_ready=1, connected to the OR block → out_data=0xFF once the slave counter passes 50; txn_count=1; bus writes seen at addresses 4 then 5 in order.
- Three back-to-back pairs (0x01,0x02), (0x10,0x20), (0xAA,0x55) → outputs 0x03, 0x30, 0xFF in order; txn_count=3; in_ready=0 throughout each transaction.
- Stub slave with read_rdy/write_rdy toggled 0 on alternate cycles → address, data and strobe held stable while rdy=0; result still A|B; no duplicate read of address 3.
- Stub slave returning status address 2 = 0x00 forever → timeout_err=1 after 1000 cycles in POLL_Y; FSM returns to IDLE; no out_valid; txn_count unchanged; the next pair still processed.
- out_ready held 0 for 20 cycles in OUT → out_valid and out_data stable; no bus activity; in_ready=0; txn_count increments exactly once on release.
- RST_N pulsed low during WR_B → all strobes 0 asynchronously; state IDLE; in_ready=1; timeout_err=0; txn_count=0.

Source files
------------

// File: rtl/or_dut_pkg.sv
// Shared constants and FSM state type for the host driver of the register-mapped OR block.
package or_dut_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  // OR block register map
  localparam logic [ADDR_W-1:0] A_FULL_N  = 3'd0;
  localparam logic [ADDR_W-1:0] B_FULL_N  = 3'd1;
  localparam logic [ADDR_W-1:0] Y_EMPTY_N = 3'd2;
  localparam logic [ADDR_W-1:0] Y_DATA    = 3'd3;
  localparam logic [ADDR_W-1:0] A_DATA    = 3'd4;
  localparam logic [ADDR_W-1:0] B_DATA    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_A,
    S_WR_A,
    S_POLL_B,
    S_WR_B,
    S_POLL_Y,
    S_RD_Y,
    S_OUT
  } state_t;

  function automatic logic is_poll(input state_t s);
    return (s == S_POLL_A) || (s == S_POLL_B) || (s == S_POLL_Y);
  endfunction

endpackage

// File: rtl/or_dut_poll_timer.sv
// Poll watchdog: counts unsuccessful poll cycles; expired flags the increment that reaches the limit.
module or_dut_poll_timer
  import or_dut_pkg::*;
#(
  parameter int TMO_W        = 10,
  parameter int POLL_TIMEOUT = 1000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(POLL_TIMEOUT - 1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  // The state therefore spends exactly POLL_TIMEOUT cycles polling before abort.
  assign expired = inc && (cnt == LAST);

endmodule

// File: rtl/or_dut_host.sv
// Bus-master host for the OR block: writes A/B, polls status, reads Y and streams it out.
module or_dut_host
  import or_dut_pkg::*;
#(
  parameter int TMO_W        = 10,
  parameter int POLL_TIMEOUT = 1000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  input  logic              write_rdy,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_en,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_rdy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       txn_count
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] a_q, b_q, y_q;
  logic [15:0]       txn_q;
  logic              err_q;
  logic              in_poll, st_ok, tmo_exp;

  assign in_poll = is_poll(state);
  // Only bit 0 of a status word carries meaning.
  assign st_ok   = read_en && read_rdy && read_data[0];

  or_dut_poll_timer #(
    .TMO_W        (TMO_W),
    .POLL_TIMEOUT (POLL_TIMEOUT)
  ) u_tmr (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr     (!in_poll),
    .inc     (in_poll && !st_ok),
    .expired (tmo_exp)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid)  state_nxt = S_POLL_A;
      S_POLL_A: if (st_ok)     state_nxt = S_WR_A;
                else if (tmo_exp) state_nxt = S_IDLE;
      S_WR_A:   if (write_rdy) state_nxt = S_POLL_B;
      S_POLL_B: if (st_ok)     state_nxt = S_WR_B;
                else if (tmo_exp) state_nxt = S_IDLE;
      S_WR_B:   if (write_rdy) state_nxt = S_POLL_Y;
      S_POLL_Y: if (st_ok)     state_nxt = S_RD_Y;
                else if (tmo_exp) state_nxt = S_IDLE;
      S_RD_Y:   if (read_rdy)  state_nxt = S_OUT;
      S_OUT:    if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_q   <= '0;
      b_q   <= '0;
      y_q   <= '0;
      txn_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (state == S_RD_Y && read_rdy) y_q <= read_data;
      if (state == S_OUT && out_ready) txn_q <= txn_q + 16'd1;
      if (in_poll && tmo_exp)          err_q <= 1'b1;
    end
  end

  // Bus and stream controls decode from the state register only, so a held beat stays stable.
  always_comb begin
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    write_en      = 1'b0;
    write_address = '0;
    write_data    = '0;
    read_en       = 1'b0;
    read_address  = '0;
    case (state)
      S_IDLE:   in_ready = 1'b1;
      S_POLL_A: begin read_en = 1'b1; read_address = A_FULL_N;  end
      S_WR_A:   begin write_en = 1'b1; write_address = A_DATA; write_data = a_q; end
      S_POLL_B: begin read_en = 1'b1; read_address = B_FULL_N;  end
      S_WR_B:   begin write_en = 1'b1; write_address = B_DATA; write_data = b_q; end
      S_POLL_Y: begin read_en = 1'b1; read_address = Y_EMPTY_N; end
      S_RD_Y:   begin read_en = 1'b1; read_address = Y_DATA;    end
      S_OUT:    out_valid = 1'b1;
      default:  ;
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign out_data    = y_q;
  assign timeout_err = err_q;
  assign txn_count   = txn_q;

endmodule

// File: tb/tb_or_dut_host.sv
// Directed bench for or_dut_host against a behavioural OR-block stub with a stream/bus scoreboard.
module tb_or_dut_host;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        in_valid, in_ready;
  logic [7:0]  in_a, in_b;
  logic [2:0]  write_address, read_address;
  logic [7:0]  write_data, read_data, out_data;
  logic        write_en, write_rdy, read_en, read_rdy;
  logic        out_valid, out_ready, busy, timeout_err;
  logic [15:0] txn_count;

  always #5 CLK = ~CLK;

  or_dut_host #(.TMO_W(10), .POLL_TIMEOUT(1000)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .write_address(write_address), .write_data(write_data), .write_en(write_en), .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en), .read_data(read_data), .read_rdy(read_rdy),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err), .txn_count(txn_count)
  );

  int npass = 0, ntot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- OR block stub (depth-1 A/B registers, gated Y) ----------------
  bit         tog = 0, stuck = 0, flush = 0;
  int         gate = 0;
  int         y_polls = 0;
  logic       a_full, b_full, phase, y_ok;
  logic [7:0] a_val, b_val, gcnt;

  always_comb begin
    y_ok      = a_full && b_full && (int'(gcnt) >= gate) && !stuck;
    read_rdy  = tog ? phase : 1'b1;
    write_rdy = tog ? ~phase : 1'b1;
    read_data = 8'h00;
    case (read_address)
      3'd0: read_data = {7'h55, !a_full};
      3'd1: read_data = {7'h55, !b_full};
      3'd2: read_data = y_ok ? 8'hAB : 8'hAA;
      3'd3: read_data = y_ok ? (a_val | b_val) : 8'h00;
      default: read_data = 8'h00;
    endcase
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_full <= 1'b0; b_full <= 1'b0; gcnt <= 8'd0; phase <= 1'b0;
      a_val  <= 8'h00; b_val <= 8'h00;
    end else begin
      phase <= ~phase;
      if (flush) begin
        a_full <= 1'b0; b_full <= 1'b0; gcnt <= 8'd0;
      end else begin
        if (write_en && write_rdy && write_address == 3'd4) begin a_full <= 1'b1; a_val <= write_data; end
        if (write_en && write_rdy && write_address == 3'd5) begin b_full <= 1'b1; b_val <= write_data; end
        if (read_en && read_rdy && read_address == 3'd3 && y_ok) begin
          a_full <= 1'b0; b_full <= 1'b0; gcnt <= 8'd0;
        end else if (a_full && b_full && gcnt != 8'hFF) gcnt <= gcnt + 8'd1;
      end
      if (read_en && read_rdy && read_address == 3'd2) y_polls <= y_polls + 1;
    end
  end

  // ---------------- scoreboard / compare process ----------------
  logic [7:0]  exp_q[$];
  logic [10:0] exp_wr[$];
  logic [7:0]  outs[$];
  logic [15:0] m_txn = 16'd0;
  int          cyc = 0, t_in = 0, lat = 0, n_out = 0, n_rd3 = 0, n_wr = 0;
  bit          first_out = 0, pw = 0, pr = 0, po = 0;
  logic [11:0] pw_v;
  logic [3:0]  pr_v;
  logic [8:0]  po_v;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RST_N) begin
      exp_q.delete(); exp_wr.delete();
      m_txn = 16'd0; pw = 0; pr = 0; po = 0; first_out = 0;
    end else begin
      chk("in_ready_idle", in_ready, !busy);
      chk("txn_count", txn_count, m_txn);
      chk("strobes_exclusive", write_en & read_en, 0);
      if (!write_en) chk("wr_idle", {write_address, write_data}, 0);
      if (!read_en)  chk("rd_idle", read_address, 0);
      if (out_valid) chk("quiet_in_out", {write_en, read_en, in_ready}, 0);
      if (pw) chk("wr_hold", {write_en, write_address, write_data}, pw_v);
      if (pr) chk("rd_hold", {read_en, read_address}, pr_v);
      if (po) chk("out_hold", {out_valid, out_data}, po_v);
      if (in_valid && in_ready) begin
        if (!stuck) exp_q.push_back(in_a | in_b);
        exp_wr.push_back({3'd4, in_a});
        exp_wr.push_back({3'd5, in_b});
        t_in = cyc; first_out = 1;
      end
      if (write_en && write_rdy) begin
        n_wr++;
        chk("wr_pending", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) chk("wr_beat", {write_address, write_data}, exp_wr.pop_front());
      end
      if (read_en && read_rdy && read_address == 3'd3) n_rd3++;
      if (out_valid) begin
        chk("out_expected", exp_q.size() > 0, 1);
        if (first_out) begin lat = cyc - t_in; first_out = 0; end
        if (out_ready && exp_q.size() > 0) begin
          chk("out_data", out_data, exp_q.pop_front());
          outs.push_back(out_data);
          n_out++;
          m_txn = m_txn + 16'd1;
        end
      end
      pw = write_en && !write_rdy; pw_v = {write_en, write_address, write_data};
      pr = read_en && !read_rdy;   pr_v = {read_en, read_address};
      po = out_valid && !out_ready; po_v = {out_valid, out_data};
    end
  end

  // ---------------- stimulus (all driving at posedge+1) ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit keep);
    int n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 3000) begin @(posedge CLK); #1; n++; end
    if (!in_ready) chk("send_accept", in_ready, 1);
    @(posedge CLK); #1;
    if (keep) begin in_a = 8'hEE; in_b = 8'hEE; end
    else in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int target);
    int n = 0;
    while (n_out < target && n < 3000) begin @(posedge CLK); #1; n++; end
    chk("wait_outs", n_out, target);
  endtask

  initial begin
    int n, p0;
    in_valid = 0; in_a = 0; in_b = 0; out_ready = 1; RST_N = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {write_en, read_en, out_valid}, 0);
    chk("rst_bus", {write_address, read_address, write_data}, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_out_data", out_data, 0);
    RST_N = 1;
    @(posedge CLK); #1;

    gate = 50;
    send(8'h0F, 8'hF0, 0);
    wait_outs(1);
    chk("t1_out", outs[0], 8'hFF);
    chk("t1_txn", txn_count, 1);
    chk("t1_writes", n_wr, 2);

    gate = 0;
    send(8'h3C, 8'h81, 0);
    wait_outs(2);
    chk("min_latency", lat, 7);
    chk("lat_out", outs[1], 8'hBD);

    send(8'h01, 8'h02, 1);
    send(8'h10, 8'h20, 1);
    send(8'hAA, 8'h55, 0);
    wait_outs(5);
    chk("b2b_0", outs[2], 8'h03);
    chk("b2b_1", outs[3], 8'h30);
    chk("b2b_2", outs[4], 8'hFF);
    chk("b2b_txn", txn_count, 5);

    tog = 1;
    send(8'h5A, 8'h24, 0);
    wait_outs(6);
    chk("tog_out", outs[5], 8'h7E);
    chk("tog_rd3", n_rd3, 6);
    tog = 0;

    p0 = y_polls; stuck = 1;
    send(8'h11, 8'h22, 0);
    n = 0;
    while (busy && n < 3000) begin @(posedge CLK); #1; n++; end
    chk("tmo_idle", busy, 0);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_polls", y_polls - p0, 1000);
    chk("tmo_txn", txn_count, 6);
    chk("tmo_no_out", n_out, 6);
    flush = 1; @(posedge CLK); #1; flush = 0; stuck = 0;
    send(8'h40, 8'h04, 0);
    wait_outs(7);
    chk("post_tmo_out", outs[6], 8'h44);
    chk("err_sticky", timeout_err, 1);

    out_ready = 0;
    send(8'h81, 8'h18, 0);
    n = 0;
    while (!out_valid && n < 3000) begin @(posedge CLK); #1; n++; end
    repeat (20) begin
      @(posedge CLK); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h99);
      chk("stall_txn", txn_count, 7);
    end
    out_ready = 1;
    wait_outs(8);
    chk("stall_release_txn", txn_count, 8);
    chk("stall_release_idle", in_ready, 1);

    send(8'h12, 8'h34, 0);
    n = 0;
    while (!(write_en && write_address == 3'd5) && n < 3000) begin @(posedge CLK); #1; n++; end
    chk("reach_wr_b", {write_en, write_address}, 4'hD);
    #2 RST_N = 0;
    #1;
    chk("arst_strobes", {write_en, read_en, out_valid}, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_err", timeout_err, 0);
    chk("arst_txn", txn_count, 0);
    @(posedge CLK); #1; RST_N = 1;
    @(posedge CLK); #1;
    send(8'h0A, 8'h50, 0);
    wait_outs(9);
    chk("post_rst_out", outs[8], 8'h5A);
    chk("post_rst_txn", txn_count, 1);
    chk("no_dup_rd3", n_rd3, n_out);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
